// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch block: state encoding,
// default widths and the program image generator used by the ROM.
// Imported by instr_rom and instr_fetch.
package Definitions;

  localparam int PC_W_C  = 10;
  localparam int IW_C    = 9;
  localparam int CNT_W_C = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Program image: one word per address, truncated to the instruction
  // width by the ROM. Kept as a constant function so the ROM needs no
  // external memory file and elaborates to pure logic.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'd13) ^ (a >> 3) ^ 32'h0000_00A5;
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Instruction store: 2^PC_W words of IW bits, initialised from the package image.
// Latency: zero, purely combinational read.
// Backpressure: none; the address is always serviced.
module instr_rom
  import Definitions::*;
#(
  parameter int PC_W = PC_W_C,
  parameter int IW   = IW_C
) (
  input  logic [PC_W-1:0] addr,
  output logic [IW-1:0]   data
);

  logic [IW-1:0] mem [2**PC_W];

  // Fill every location from the program image generator.
  for (genvar i = 0; i < 2**PC_W; i++) begin : g_init
    assign mem[i] = IW'(rom_word(32'(i)));
  end

  assign data = mem[addr];

endmodule

// File: rtl/instr_fetch.sv
// Program counter sequencer with IDLE/RUN/HALT control and ROM fetch.
// Latency: Instruction follows PC combinationally; PC moves one edge after the flags.
// Backpressure: Stall holds the PC; Ack halts and takes priority over stall and branch.
module instr_fetch
  import Definitions::*;
#(
  parameter int PC_W  = PC_W_C,
  parameter int IW    = IW_C,
  parameter int CNT_W = CNT_W_C
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  Start_Addr,
  input  logic             PC_Jmp_Flag,
  input  logic             PC_Beq_Flag,
  input  logic [PC_W-1:0]  Target,
  input  logic             Ack,
  input  logic             Stall,
  output logic [PC_W-1:0]  PC,
  output logic [IW-1:0]    Instruction,
  output logic             Instr_Valid,
  output logic             Done,
  output logic [CNT_W-1:0] Cycle_Count
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state, next-PC and cycle counter; everything holds unless changed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = Start_Addr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Every RUN cycle counts, stalled or halting ones included.
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (Ack) begin
          state_d = HALT;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (PC_Jmp_Flag || PC_Beq_Flag) begin
          pc_d = Target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over any request in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status decoded from registered state only.
  assign Instr_Valid = (state_q == RUN);
  assign Done        = (state_q == HALT);
  assign PC          = pc_q;
  assign Cycle_Count = cnt_q;

  instr_rom #(
    .PC_W (PC_W),
    .IW   (IW)
  ) u_rom (
    .addr (pc_q),
    .data (Instruction)
  );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [9:0]  Start_Addr;
  logic        PC_Jmp_Flag;
  logic        PC_Beq_Flag;
  logic [9:0]  Target;
  logic        Ack;
  logic        Stall;
  logic [9:0]  PC;
  logic [8:0]  Instruction;
  logic        Instr_Valid;
  logic        Done;
  logic [15:0] Cycle_Count;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Start_Addr  (Start_Addr),
    .PC_Jmp_Flag (PC_Jmp_Flag),
    .PC_Beq_Flag (PC_Beq_Flag),
    .Target      (Target),
    .Ack         (Ack),
    .Stall       (Stall),
    .PC          (PC),
    .Instruction (Instruction),
    .Instr_Valid (Instr_Valid),
    .Done        (Done),
    .Cycle_Count (Cycle_Count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] cnt;
    logic        vld;
    logic        done;
    logic [8:0]  instr;
  } exp_t;

  exp_t sb[$];

  // Reference model state: 0 = idle, 1 = run, 2 = halted.
  int          m_state = 0;
  logic [9:0]  m_pc    = '0;
  logic [15:0] m_cnt   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected program word at an address, from the program image definition.
  function automatic logic [8:0] exp_instr(input logic [9:0] a);
    logic [31:0] w;
    w = (32'(a) * 13) ^ (32'(a) >> 3) ^ 32'hA5;
    return w[8:0];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.pc    = m_pc;
    e.cnt   = m_cnt;
    e.vld   = (m_state == 1);
    e.done  = (m_state == 2);
    e.instr = exp_instr(m_pc);
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model, push its prediction,
  // then pop and compare against the DUT after the edge.
  task automatic cyc(input logic rst_n, input logic st, input logic [9:0] sa,
                     input logic jmp, input logic beq, input logic [9:0] tg,
                     input logic ack, input logic stl);
    exp_t e;
    Reset_n = rst_n; Start = st; Start_Addr = sa; PC_Jmp_Flag = jmp;
    PC_Beq_Flag = beq; Target = tg; Ack = ack; Stall = stl;
    if (!rst_n) begin
      m_state = 0; m_pc = '0; m_cnt = '0;
    end else if (m_state != 1) begin
      if (st) begin m_state = 1; m_pc = sa; m_cnt = '0; end
    end else begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (ack)            m_state = 2;
      else if (stl)       m_pc = m_pc;
      else if (jmp | beq) m_pc = tg;
      else                m_pc = m_pc + 10'd1;
    end
    sb.push_back(model_out());
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check("pc",    32'(PC),          32'(e.pc));
    check("cnt",   32'(Cycle_Count), 32'(e.cnt));
    check("vld",   32'(Instr_Valid), 32'(e.vld));
    check("done",  32'(Done),        32'(e.done));
    check("instr", 32'(Instruction), 32'(e.instr));
  endtask

  task automatic idle_cyc();             cyc(1, 0, 10'h0, 0, 0, 10'h0, 0, 0); endtask
  task automatic jump(input logic [9:0] t); cyc(1, 0, 10'h0, 1, 0, t, 0, 0);   endtask

  logic [15:0] cnt_before;

  initial begin
    Reset_n = 0; Start = 0; Start_Addr = '0; PC_Jmp_Flag = 0; PC_Beq_Flag = 0;
    Target = '0; Ack = 0; Stall = 0;

    // Reset with Start held: reset must win.
    cyc(0, 1, 10'h155, 0, 0, 10'h0, 0, 0);
    cyc(0, 1, 10'h155, 0, 0, 10'h0, 0, 0);
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_cnt", 32'(Cycle_Count), 32'h0);
    check("rst_vld", 32'(Instr_Valid), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    idle_cyc();
    idle_cyc();
    check("idle_hold_pc", 32'(PC), 32'h0);

    // Start at 0x010 then four sequential fetches.
    cyc(1, 1, 10'h010, 0, 0, 10'h0, 0, 0);
    check("start_pc", 32'(PC), 32'h010);
    check("start_cnt", 32'(Cycle_Count), 32'h0);
    for (int i = 0; i < 4; i++) idle_cyc();
    check("seq_pc", 32'(PC), 32'h014);
    check("seq_cnt", 32'(Cycle_Count), 32'd4);
    check("seq_vld", 32'(Instr_Valid), 32'h1);

    // Jump and branch redirects.
    jump(10'h020);
    jump(10'h3F0);
    check("jmp_pc", 32'(PC), 32'h3F0);
    jump(10'h020);
    cyc(1, 0, 10'h0, 0, 1, 10'h005, 0, 0);
    check("beq_pc", 32'(PC), 32'h005);
    cyc(1, 0, 10'h0, 1, 1, 10'h2AA, 0, 0);
    check("both_flags_pc", 32'(PC), 32'h2AA);

    // Wrap from the top of the address space.
    jump(10'h3FF);
    idle_cyc();
    check("wrap_pc", 32'(PC), 32'h000);

    // Three stalled cycles hold PC but still count.
    jump(10'h050);
    cnt_before = Cycle_Count;
    for (int i = 0; i < 3; i++) cyc(1, 0, 10'h0, 0, 0, 10'h0, 0, 1);
    check("stall_pc", 32'(PC), 32'h050);
    check("stall_cnt", 32'(Cycle_Count), 32'(cnt_before + 16'd3));

    // Start during RUN is ignored.
    cyc(1, 1, 10'h200, 0, 0, 10'h0, 0, 0);
    check("start_in_run_pc", 32'(PC), 32'h051);

    // Halt wins over stall and jump, then restart.
    jump(10'h030);
    cyc(1, 0, 10'h0, 1, 0, 10'h111, 1, 1);
    check("halt_pc", 32'(PC), 32'h030);
    check("halt_done", 32'(Done), 32'h1);
    check("halt_vld", 32'(Instr_Valid), 32'h0);
    cyc(1, 0, 10'h0, 1, 1, 10'h222, 0, 0);
    check("halt_hold_pc", 32'(PC), 32'h030);
    cyc(1, 1, 10'h100, 0, 0, 10'h0, 0, 0);
    check("restart_pc", 32'(PC), 32'h100);
    check("restart_cnt", 32'(Cycle_Count), 32'h0);
    check("restart_done", 32'(Done), 32'h0);

    // Reset mid-RUN with Start asserted.
    jump(10'h123);
    cyc(0, 1, 10'h3C0, 0, 0, 10'h0, 0, 0);
    check("midrst_pc", 32'(PC), 32'h0);
    check("midrst_cnt", 32'(Cycle_Count), 32'h0);
    check("midrst_vld", 32'(Instr_Valid), 32'h0);

    // Random mixed traffic against the scoreboard model.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
          10'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
          10'($urandom), ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0));
    end

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
